// File: rtl/bus_master_pkg.sv
// bus_master_pkg: shared types and constants for the bus master port.
//   master_state_t : handshake FSM states
//   bus_cmd_t      : latched local command (direction, address, write data)
//   RETRY_MAX      : reissues allowed after an arbiter error (retry build only)
// The command struct is sized by BUS_ADDR_W/BUS_DATA_W; the port's ADDR_WIDTH
// and DATA_WIDTH default to these and must be kept equal to them.
package bus_master_pkg;

   localparam int BUS_ADDR_W = 16;
   localparam int BUS_DATA_W = 16;

   localparam logic [1:0] RETRY_MAX = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      GRANT,
      ADDR,
      RELEASE
   } master_state_t;

   typedef struct packed {
      logic                  write;
      logic [BUS_ADDR_W-1:0] addr;
      logic [BUS_DATA_W-1:0] wdata;
   } bus_cmd_t;

endpackage

// File: rtl/bus_master_port_timeout_counter.sv
// timeout_counter: cycle counter with terminal-count flag.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear to zero (wins over en)
//   en         : count up by one this cycle
//   tc         : high in the cycle whose increment would reach MAX_COUNT
module timeout_counter #(
   parameter int MAX_COUNT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = $clog2(MAX_COUNT + 1);
   localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   // Flagged one cycle early so the owner leaves on the edge where the count
   // would hit MAX_COUNT, i.e. after exactly MAX_COUNT enabled cycles.
   assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/bus_master_port.sv
// bus_master_port: master-side request/grant/address/strobe handshake engine.
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_*                 : single read/write command in (valid/ready)
//   rsp_*                 : one-cycle response pulse with read data / error
//   barq_o, bagd_i        : bus request / grant with the arbiter
//   target_ready_i, address_valid_o, data_strobe_i, error_i : arbiter handshake
//   bus_addr_o, bus_wdata_o, bus_write_o, bus_oe_o, bus_rdata_i : bus datapath
// Optional: BUS_MASTER_RETRY_EN reissues a command up to RETRY_MAX times after
// an arbiter error before reporting it; grant timeouts are never retried.
import bus_master_pkg::*;

module bus_master_port #(
   parameter int ADDR_WIDTH    = BUS_ADDR_W,
   parameter int DATA_WIDTH    = BUS_DATA_W,
   parameter int GRANT_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_error_o,
   output logic                  barq_o,
   input  logic                  bagd_i,
   input  logic                  target_ready_i,
   output logic                  address_valid_o,
   input  logic                  data_strobe_i,
   input  logic                  error_i,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   output logic                  bus_write_o,
   output logic                  bus_oe_o,
   input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

   master_state_t         state, state_n;
   bus_cmd_t              cmd_q, cmd_n;
   logic                  err_q, err_n;          // outcome of the current attempt
   logic [DATA_WIDTH-1:0] rdata_q, rdata_n;      // data captured on the strobe
   logic                  rsp_v_n, rsp_err_n;
   logic [DATA_WIDTH-1:0] rsp_rdata_n;
   logic                  grant_tc;
`ifdef BUS_MASTER_RETRY_EN
   logic [1:0]            retry_cnt, retry_n;
`endif

   // Counts REQ cycles; a grant restarts it so a later retry gets a full window.
   timeout_counter #(.MAX_COUNT(GRANT_TIMEOUT)) u_grant_to (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((state != REQ) || bagd_i),
      .en    (state == REQ),
      .tc    (grant_tc)
   );

   // Handshake outputs decode straight from state, so a reset drops them on
   // the very next edge.
   assign cmd_ready_o     = (state == IDLE);
   assign barq_o          = (state == REQ) || (state == GRANT) || (state == ADDR);
   assign bus_oe_o        = (state == GRANT) || (state == ADDR);
   assign address_valid_o = (state == ADDR);
   assign bus_addr_o      = cmd_q.addr;
   assign bus_wdata_o     = cmd_q.wdata;
   assign bus_write_o     = cmd_q.write;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_q       <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_error_o <= 1'b0;
`ifdef BUS_MASTER_RETRY_EN
         retry_cnt   <= '0;
`endif
      end else begin
         state       <= state_n;
         cmd_q       <= cmd_n;
         err_q       <= err_n;
         rdata_q     <= rdata_n;
         rsp_valid_o <= rsp_v_n;
         rsp_rdata_o <= rsp_rdata_n;
         rsp_error_o <= rsp_err_n;
`ifdef BUS_MASTER_RETRY_EN
         retry_cnt   <= retry_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      cmd_n       = cmd_q;
      err_n       = err_q;
      rdata_n     = rdata_q;
      rsp_v_n     = 1'b0;
      rsp_rdata_n = rsp_rdata_o;
      rsp_err_n   = rsp_error_o;
`ifdef BUS_MASTER_RETRY_EN
      retry_n     = retry_cnt;
`endif
      case (state)
         IDLE: begin
            if (cmd_valid_i) begin
               cmd_n   = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
               err_n   = 1'b0;
               rdata_n = '0;
`ifdef BUS_MASTER_RETRY_EN
               retry_n = '0;
`endif
               state_n = REQ;
            end
         end
         REQ: begin
            if (bagd_i) begin
               state_n = GRANT;
            end else if (grant_tc) begin
               // Local abort: answer directly, no RELEASE since we never held the bus.
               rsp_v_n     = 1'b1;
               rsp_err_n   = 1'b1;
               rsp_rdata_n = '0;
               state_n     = IDLE;
            end
         end
         GRANT: begin
            if (error_i) begin
               err_n   = 1'b1;
               state_n = RELEASE;
            end else if (target_ready_i) begin
               state_n = ADDR;
            end
         end
         ADDR: begin
            // Strobe beats a coincident error; only the first strobe cycle counts.
            if (data_strobe_i) begin
               rdata_n = cmd_q.write ? '0 : bus_rdata_i;
               err_n   = 1'b0;
               state_n = RELEASE;
            end else if (error_i) begin
               err_n   = 1'b1;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            if (!bagd_i) begin
`ifdef BUS_MASTER_RETRY_EN
               if (err_q && (retry_cnt < RETRY_MAX)) begin
                  retry_n = retry_cnt + 2'd1;
                  err_n   = 1'b0;
                  state_n = REQ;
               end else begin
                  rsp_v_n     = 1'b1;
                  rsp_rdata_n = rdata_q;
                  rsp_err_n   = err_q;
                  state_n     = IDLE;
               end
`else
               rsp_v_n     = 1'b1;
               rsp_rdata_n = rdata_q;
               rsp_err_n   = err_q;
               state_n     = IDLE;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: directed transactions against a cycle-scripted
// arbiter; expected responses are queued at issue and checked by a monitor.
module tb_bus_master_port;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_wdata_i;
   logic          rsp_valid_o, rsp_error_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          barq_o, bagd_i, target_ready_i, address_valid_o;
   logic          data_strobe_i, error_i;
   logic [AW-1:0] bus_addr_o;
   logic [DW-1:0] bus_wdata_o;
   logic          bus_write_o, bus_oe_o;
   logic [DW-1:0] bus_rdata_i;

   bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANT_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
      .barq_o(barq_o), .bagd_i(bagd_i), .target_ready_i(target_ready_i),
      .address_valid_o(address_valid_o), .data_strobe_i(data_strobe_i), .error_i(error_i),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_write_o(bus_write_o),
      .bus_oe_o(bus_oe_o), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   rsp_seen = 0;
   int   rsp_pushed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic expect_rsp(input logic [DW-1:0] rd, input logic err);
      rsp_t r;
      r.rdata = rd;
      r.err   = err;
      exp_q.push_back(r);
      rsp_pushed++;
   endtask

   // Monitor: every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid_o) begin
         rsp_seen++;
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", {16'd0, rsp_rdata_o}, {16'd0, e.rdata});
            chk("rsp_error", {31'd0, rsp_error_o}, {31'd0, e.err});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   // Present a command and let it be accepted; checks the latched bus fields.
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid_i = 1'b1;
      cmd_write_i = w;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
      cyc;
      cmd_valid_i = 1'b0;
      chk("barq_after_accept", {31'd0, barq_o}, 32'd1);
      chk("bus_addr", {16'd0, bus_addr_o}, {16'd0, a});
      chk("bus_wdata", {16'd0, bus_wdata_o}, {16'd0, d});
      chk("bus_write", {31'd0, bus_write_o}, {31'd0, w});
   endtask

   // Drive REQ -> GRANT -> ADDR.
   task automatic to_addr(input int gdly);
      repeat (gdly) cyc;
      chk("barq_req_wait", {31'd0, barq_o}, 32'd1);
      bagd_i = 1'b1;
      cyc;
      chk("oe_grant", {31'd0, bus_oe_o}, 32'd1);
      chk("av_grant", {31'd0, address_valid_o}, 32'd0);
      target_ready_i = 1'b1;
      cyc;
      target_ready_i = 1'b0;
      chk("av_addr", {31'd0, address_valid_o}, 32'd1);
      chk("barq_addr", {31'd0, barq_o}, 32'd1);
   endtask

   // One full bus episode from REQ: strobe (2 cycles) or error, then grant drop.
   task automatic bus_phase(input int gdly, input int sdly, input logic [DW-1:0] rd,
                            input logic err);
      to_addr(gdly);
      repeat (sdly) cyc;
      if (err) error_i = 1'b1;
      else begin
         data_strobe_i = 1'b1;
         bus_rdata_i   = rd;
      end
      cyc;
      error_i = 1'b0;
      chk("av_release", {31'd0, address_valid_o}, 32'd0);
      chk("barq_release", {31'd0, barq_o}, 32'd0);
      chk("oe_release", {31'd0, bus_oe_o}, 32'd0);
      bus_rdata_i = ~rd;        // second strobe cycle carries junk that must be ignored
      cyc;
      data_strobe_i = 1'b0;
      bagd_i        = 1'b0;
      cyc;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
      cmd_wdata_i = '0; bagd_i = 1'b0; target_ready_i = 1'b0; data_strobe_i = 1'b0;
      error_i = 1'b0; bus_rdata_i = '0;
      cyc; cyc;
      rst_n = 1'b1;
      chk("rst_barq", {31'd0, barq_o}, 32'd0);
      chk("rst_av", {31'd0, address_valid_o}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("rst_oe", {31'd0, bus_oe_o}, 32'd0);
      chk("rst_bus_addr", {16'd0, bus_addr_o}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

      // Write 0x1234 to 0x00A5, grant after 2 cycles, strobe 4 cycles after av.
      expect_rsp(16'h0000, 1'b0);
      issue(1'b1, 16'h00A5, 16'h1234);
      bus_phase(2, 3, 16'h5555, 1'b0);
      cyc;

      // Read 0x0010 returning 0xBEEF.
      expect_rsp(16'hBEEF, 1'b0);
      issue(1'b0, 16'h0010, 16'h0000);
      bus_phase(1, 0, 16'hBEEF, 1'b0);
      cyc;

      // Grant never comes: abort after exactly TO request cycles.
      expect_rsp(16'h0000, 1'b1);
      issue(1'b0, 16'h0200, 16'h0000);
      n = 0;
      while (barq_o && n < 20) begin
         if (address_valid_o) chk("timeout_no_av", 32'd1, 32'd0);
         n++;
         cyc;
      end
      chk("timeout_barq_cycles", n, TO);
      cyc;

`ifdef BUS_MASTER_RETRY_EN
      // Three failing episodes before the error is reported.
      expect_rsp(16'h0000, 1'b1);
      issue(1'b0, 16'h0300, 16'h0000);
      bus_phase(0, 1, 16'h0000, 1'b1);
      chk("retry1_barq", {31'd0, barq_o}, 32'd1);
      bus_phase(0, 1, 16'h0000, 1'b1);
      chk("retry2_barq", {31'd0, barq_o}, 32'd1);
      bus_phase(0, 1, 16'h0000, 1'b1);
      cyc;
      // Success on the second attempt.
      expect_rsp(16'hC0DE, 1'b0);
      issue(1'b0, 16'h0301, 16'h0000);
      bus_phase(0, 1, 16'h0000, 1'b1);
      bus_phase(1, 0, 16'hC0DE, 1'b0);
      cyc;
`else
      // Arbiter error in ADDR without a strobe.
      expect_rsp(16'h0000, 1'b1);
      issue(1'b0, 16'h0300, 16'h0000);
      bus_phase(0, 1, 16'h0000, 1'b1);
      cyc;
`endif

      // Reset while in ADDR: everything drops, no response.
      issue(1'b0, 16'h0400, 16'h0000);
      to_addr(1);
      rst_n = 1'b0;
      cyc;
      rst_n  = 1'b1;
      bagd_i = 1'b0;
      chk("midrst_barq", {31'd0, barq_o}, 32'd0);
      chk("midrst_av", {31'd0, address_valid_o}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("midrst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      cyc; cyc;

      // Back-to-back with cmd_valid held: second accepted only on the response cycle.
      expect_rsp(16'h0000, 1'b0);
      issue(1'b1, 16'h0A0A, 16'h1111);
      cmd_valid_i = 1'b1;
      cmd_addr_i  = 16'h0B0B;
      cmd_wdata_i = 16'h2222;
      bus_phase(1, 1, 16'h0000, 1'b0);
      chk("b2b_rsp_cycle", {31'd0, rsp_valid_o}, 32'd1);
      chk("b2b_held_addr", {16'd0, bus_addr_o}, 32'h0A0A);
      chk("b2b_barq_gap", {31'd0, barq_o}, 32'd0);
      expect_rsp(16'h0000, 1'b0);
      cyc;
      cmd_valid_i = 1'b0;
      chk("b2b_second_addr", {16'd0, bus_addr_o}, 32'h0B0B);
      chk("b2b_second_barq", {31'd0, barq_o}, 32'd1);
      bus_phase(0, 0, 16'h0000, 1'b0);
      cyc; cyc;

      chk("rsp_count", rsp_seen, rsp_pushed);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side handshake engine; one instance per bus master, directly upstream of the bus arbiter.
- Accepts single read/write commands from local logic and raises barq toward the arbiter.
- Waits for bagd, then target_ready, drives address/data and address_valid, and completes on data_strobe.
- Returns read data or an error status to the local logic.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- GRANT_TIMEOUT, 255, max cycles in REQ waiting for bagd before local abort; must be >=1; counter width = $clog2(GRANT_TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted this cycle when valid&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  command address
- cmd_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  DATA_WIDTH  read data, valid with rsp_valid_o
- rsp_error_o  out  1  1=arbiter error or grant timeout, valid with rsp_valid_o
- barq_o  out  1  bus request to arbiter
- bagd_i  in  1  bus grant from arbiter (this master's bit)
- target_ready_i  in  1  arbiter target_ready
- address_valid_o  out  1  address/data valid to arbiter
- data_strobe_i  in  1  arbiter data strobe (2-cycle pulse)
- error_i  in  1  arbiter timeout error
- bus_addr_o  out  ADDR_WIDTH  registered address
- bus_wdata_o  out  DATA_WIDTH  registered write data
- bus_write_o  out  1  registered direction
- bus_oe_o  out  1  bus drive enable; high in GRANT and ADDR
- bus_rdata_i  in  DATA_WIDTH  bus read data

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; command registers 0; counter 0. Reset mid-transaction drops barq_o/address_valid_o next edge, with no response.
- Clock/reset: one clock; reset synchronous, active-low.
- States: IDLE, REQ, GRANT, ADDR, RELEASE.
- IDLE:
  - cmd_ready_o=1 combinationally only in IDLE.
  - On cmd_valid_i: latch write/addr/wdata into bus_*_o, set barq_o=1, go to REQ.
- REQ:
  - barq_o=1; grant counter increments each cycle.
  - bagd_i=1 -> GRANT, counter cleared.
  - Counter reaches GRANT_TIMEOUT with no bagd_i -> response error=1, barq_o=0, go to IDLE.
- GRANT:
  - barq_o=1, bus_oe_o=1.
  - target_ready_i=1 -> address_valid_o=1 next cycle, go to ADDR.
  - error_i=1 -> RELEASE with error.
- ADDR:
  - barq_o=1, address_valid_o=1.
  - First cycle data_strobe_i=1: capture bus_rdata_i into rsp_rdata_o (reads; writes give 0), rsp_error_o=0, drop address_valid_o and bus_oe_o, go to RELEASE.
  - error_i=1 with data_strobe_i=0 -> RELEASE with error=1.
  - Simultaneous data_strobe_i and error_i: strobe wins, error=0.
- RELEASE:
  - barq_o=0.
  - Wait bagd_i=0, then rsp_valid_o=1 for one cycle and return to IDLE.
  - The second data_strobe_i cycle and any further error_i are ignored.
- Latency: cmd accept to barq_o high = 1 cycle. Response = 1 cycle after bagd_i falls.
- rsp_rdata_o/rsp_error_o hold until the next response; rsp_valid_o is 0 otherwise.
- No new command is accepted before rsp_valid_o. cmd_ready_o never overlaps rsp_valid_o in the same transaction.

Optional Feature:
- BUS_MASTER_RETRY_EN defined:
  - On arbiter error_i (not grant timeout), reissue up to 2 times: drop barq_o, pass RELEASE, re-enter REQ with the latched command.
  - rsp_error_o=1 only after the 3rd failure.
  - A 2-bit retry count is exposed as internal debug signal retry_cnt.
- Undefined: first error_i completes with rsp_error_o=1.

Decomposition:
- Package bus_master_pkg holds:
  - state enum master_state_t {IDLE, REQ, GRANT, ADDR, RELEASE};
  - command struct bus_cmd_t {write, addr, wdata};
  - constant RETRY_MAX=2.
- The grant-timeout counter is a natural sub-module, timeout_counter (clear, enable, terminal count flag).
- FSM and datapath stay in bus_master_port.

Test Plan:
- Write 0x1234 to 0x00A5; arbiter model grants after 2 cycles, strobe 4 cycles after address_valid -> bus_addr_o=0x00A5, bus_wdata_o=0x1234, one rsp_valid_o with error=0, barq_o low in RELEASE.
- Read 0x0010 with bus_rdata_i=0xBEEF during strobe -> rsp_rdata_o=0xBEEF, error=0; second strobe cycle ignored, single rsp_valid_o.
- bagd_i never asserted, GRANT_TIMEOUT=8 -> barq_o drops after 8 REQ cycles, rsp_valid_o with error=1, no address_valid_o ever.
- error_i in ADDR (no strobe) -> RELEASE, rsp_error_o=1. With BUS_MASTER_RETRY_EN: 3 barq_o episodes then error=1; success on 2nd try gives error=0.
- rst_n low for 1 cycle while in ADDR -> next cycle barq_o=0, address_valid_o=0, rsp_valid_o=0, cmd_ready_o=1.
- Back-to-back commands with cmd_valid_i held -> second command accepted only after rsp_valid_o; barq_o low for at least 1 cycle between them.
